karatsuba_sequencer: RTL and testbench
======================================

Name: karatsuba_sequencer

Overview:
- One-level Karatsuba multiply controller: splits two WIDTH-bit operands into halves and issues the three partial products (z0, z1, z2) in sequence to a single shared (HALF+1)-bit multiplier.
- Combines the partial products into the full 2*WIDTH-bit product.
- Sits between the modexp/keygen datapath (requester side) and the shared sub-multiplier, so one multiplier instance serves full-width multiplies.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.
- HALF, WIDTH/2, split point; derived, not overridden.

Ports:
- clk_in  input  1  system clock; all state changes on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- valid_in  input  1  request strobe; operands accepted when valid_in && ready_out.
- input_1  input  WIDTH  multiplicand.
- input_2  input  WIDTH  multiplier.
- ready_out  output  1  high when in IDLE and able to accept.
- output_valid  output  1  one-cycle pulse; product valid.
- product  output  2*WIDTH  result; held until next result or reset.
- mul_start_out  output  1  one-cycle start pulse to shared multiplier.
- mul_a_out  output  HALF+1  sub-multiplier operand A; stable from start until result captured.
- mul_b_out  output  HALF+1  sub-multiplier operand B; same stability rule.
- mul_ready_in  input  1  sub-multiplier result-valid pulse.
- mul_product_in  input  2*HALF+2  sub-multiplier result.

Behaviour:
- Reset (rst_in low, async): state=IDLE; output_valid, mul_start_out, product, mul_a_out, mul_b_out, internal z regs = 0. ready_out=1 once in IDLE. Reset mid-operation aborts with no output pulse. A late mul_ready_in arriving after reset is ignored.
- Split: l1=input_1[HALF-1:0], h1=input_1[WIDTH-1:HALF]; likewise l2/h2. Operands are latched on accept; input_1/input_2 may change afterward.
- FSM states: IDLE, Z0_ISSUE, Z0_WAIT, Z1_ISSUE, Z1_WAIT, Z2_ISSUE, Z2_WAIT, COMBINE.
  - IDLE -> Z0_ISSUE on accept.
  - Each *_ISSUE lasts exactly 1 cycle with mul_start_out=1, then moves to *_WAIT.
  - *_WAIT holds until mul_ready_in=1, captures mul_product_in, then moves to the next ISSUE or to COMBINE.
  - COMBINE lasts 1 cycle, registers product, sets output_valid=1 for the following cycle, returns to IDLE.
- Operand sets (zero-extended to HALF+1 bits):
  - z0: A=l1, B=l2.
  - z1: A=l1+h1, B=l2+h2 (carry kept in bit HALF).
  - z2: A=h1, B=h2.
- Fast path: if h1==0 and h2==0 at accept, Z0_WAIT goes directly to COMBINE and product=z0 (z1/z2 never issued).
- Combine: product = (z2 << 2*HALF) + ((z1 - z2 - z0) << HALF) + z0.
  - Middle term is computed at 2*HALF+2 bits and is always non-negative.
  - The final sum is truncated to 2*WIDTH bits; no overflow can occur.
- mul_ready_in is ignored in IDLE, in any *_ISSUE cycle, and in COMBINE. The sub-multiplier latency L must be >= 1 cycle after the start cycle.
- Latency: with sub-multiplier latency L, output_valid is high on cycle 3(L+1)+2 after the accepting edge (8 for L=1); fast path is (L+1)+2 (4 for L=1).
- Throughput: ready_out=1 in the same cycle output_valid=1, so back-to-back requests are allowed. valid_in while ready_out=0 is ignored (not queued).
- No stall on output side: the output_valid pulse is not held for a consumer.

Test Plan:
- WIDTH=8, L=1, input_1=0xAB, input_2=0xCD -> mul operand pairs (0x0B,0x0D), (0x15,0x19), (0x0A,0x0C) in order; product=0x88EF, output_valid 8 cycles after accept.
- WIDTH=8, input_1=0xFF, input_2=0xFF -> z1 operands (0x1E,0x1E) with carry bit set; product=0xFE01.
- WIDTH=8, input_1=0x0C, input_2=0x09 -> fast path, one mul_start_out pulse only; product=0x006C, output_valid 4 cycles after accept.
- WIDTH=8, sub-multiplier latency varied 1/3/5 per phase, operands 0x00 x 0xA5 and 0x80 x 0x02 -> products 0x0000 and 0x0100; mul_a_out/mul_b_out stable through each WAIT.
- Back-to-back: assert valid_in on the output_valid cycle with new operands 0x12 x 0x34 -> accepted immediately, product=0x03A8; valid_in while busy is ignored.
- Drive rst_in low during Z1_WAIT, then inject a stray mul_ready_in after release -> no output_valid, all outputs 0, ready_out=1; next request 0xAB x 0xCD yields 0x88EF.

Source files
------------

// File: rtl/karatsuba_sequencer.sv
// karatsuba_sequencer: one-level Karatsuba multiply controller.
// Splits two WIDTH-bit operands into halves and issues the z0, z1 and z2
// partial products, one after another, to a single shared (HALF+1)-bit
// multiplier. It then recombines them into the full 2*WIDTH-bit product.
// When both upper halves are zero only z0 is needed, so z1 and z2 are skipped.
module karatsuba_sequencer #(
  parameter  int WIDTH = 32,
  localparam int HALF  = WIDTH / 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                valid_in,
  input  logic [WIDTH-1:0]    input_1,
  input  logic [WIDTH-1:0]    input_2,
  output logic                ready_out,
  output logic                output_valid,
  output logic [2*WIDTH-1:0]  product,
  output logic                mul_start_out,
  output logic [HALF:0]       mul_a_out,
  output logic [HALF:0]       mul_b_out,
  input  logic                mul_ready_in,
  input  logic [2*HALF+1:0]   mul_product_in
);

  localparam int PW = 2 * WIDTH;
  localparam int ZW = 2 * HALF + 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_Z0_ISSUE = 3'd1,
    ST_Z0_WAIT  = 3'd2,
    ST_Z1_ISSUE = 3'd3,
    ST_Z1_WAIT  = 3'd4,
    ST_Z2_ISSUE = 3'd5,
    ST_Z2_WAIT  = 3'd6,
    ST_COMBINE  = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [HALF-1:0] r_l1, r_h1, r_l2, r_h2;
  logic            r_fast;
  logic [ZW-1:0]   r_z0, r_z1, r_z2;
  logic [HALF:0]   r_mul_a, r_mul_b;
  logic [PW-1:0]   r_product;
  logic            r_out_valid;
  logic            w_accept;
  logic [PW-1:0]   w_combined;

  // Recombine the partial products. The middle term z1-z2-z0 equals
  // l1*h2 + h1*l2, so it is never negative at ZW bits. The fast path has
  // z1 = z2 = 0, so it bypasses the formula and uses z0 directly.
  function automatic logic [PW-1:0] combine_terms(input logic [ZW-1:0] z0,
                                                  input logic [ZW-1:0] z1,
                                                  input logic [ZW-1:0] z2,
                                                  input logic          fast);
    logic [ZW-1:0] mid;
    logic [PW-1:0] sum;
    mid = z1 - z2 - z0;
    sum = (PW'(z2) << (2 * HALF)) + (PW'(mid) << HALF) + PW'(z0);
    if (fast) sum = PW'(z0);
    return sum;
  endfunction

  assign w_accept      = valid_in && ready_out;
  assign w_combined    = combine_terms(r_z0, r_z1, r_z2, r_fast);
  assign output_valid  = r_out_valid;
  assign product       = r_product;
  assign mul_a_out     = r_mul_a;
  assign mul_b_out     = r_mul_b;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic. mul_ready_in is looked at only in the WAIT states.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_accept) w_next = ST_Z0_ISSUE;
      ST_Z0_ISSUE: w_next = ST_Z0_WAIT;
      ST_Z0_WAIT:  if (mul_ready_in) w_next = r_fast ? ST_COMBINE : ST_Z1_ISSUE;
      ST_Z1_ISSUE: w_next = ST_Z1_WAIT;
      ST_Z1_WAIT:  if (mul_ready_in) w_next = ST_Z2_ISSUE;
      ST_Z2_ISSUE: w_next = ST_Z2_WAIT;
      ST_Z2_WAIT:  if (mul_ready_in) w_next = ST_COMBINE;
      ST_COMBINE:  w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Decoded handshake outputs: accept only in IDLE, start pulse in each ISSUE.
  always_comb begin
    ready_out     = 1'b0;
    mul_start_out = 1'b0;
    case (r_state)
      ST_IDLE:                              ready_out     = 1'b1;
      ST_Z0_ISSUE, ST_Z1_ISSUE, ST_Z2_ISSUE: mul_start_out = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, sub-multiplier operands, partial-product capture and result.
  // The operands for the next phase are loaded when the current result is
  // captured, so they stay stable from the start pulse until their own capture.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_l1        <= '0;
      r_h1        <= '0;
      r_l2        <= '0;
      r_h2        <= '0;
      r_fast      <= 1'b0;
      r_z0        <= '0;
      r_z1        <= '0;
      r_z2        <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_product   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_l1    <= input_1[HALF-1:0];
            r_h1    <= input_1[WIDTH-1:HALF];
            r_l2    <= input_2[HALF-1:0];
            r_h2    <= input_2[WIDTH-1:HALF];
            r_fast  <= (input_1[WIDTH-1:HALF] == '0) && (input_2[WIDTH-1:HALF] == '0);
            r_z0    <= '0;
            r_z1    <= '0;
            r_z2    <= '0;
            r_mul_a <= {1'b0, input_1[HALF-1:0]};
            r_mul_b <= {1'b0, input_2[HALF-1:0]};
          end
        end
        ST_Z0_WAIT: begin
          if (mul_ready_in) begin
            r_z0 <= mul_product_in;
            if (!r_fast) begin
              r_mul_a <= {1'b0, r_l1} + {1'b0, r_h1};
              r_mul_b <= {1'b0, r_l2} + {1'b0, r_h2};
            end
          end
        end
        ST_Z1_WAIT: begin
          if (mul_ready_in) begin
            r_z1    <= mul_product_in;
            r_mul_a <= {1'b0, r_h1};
            r_mul_b <= {1'b0, r_h2};
          end
        end
        ST_Z2_WAIT: begin
          if (mul_ready_in) r_z2 <= mul_product_in;
        end
        ST_COMBINE: begin
          r_product   <= w_combined;
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_sequencer.sv
// Bench for karatsuba_sequencer at WIDTH=8. It drives requests, models the
// shared sub-multiplier with a per-phase latency, and compares against plain
// arithmetic: the full product a*b and the operand pairs built from the halves.
module tb_karatsuba_sequencer;

  localparam int W  = 8;
  localparam int H  = W / 2;
  localparam int PZ = 2 * H + 2;

  logic             clk_in;
  logic             rst_in;
  logic             valid_in;
  logic [W-1:0]     input_1;
  logic [W-1:0]     input_2;
  logic             ready_out;
  logic             output_valid;
  logic [2*W-1:0]   product;
  logic             mul_start_out;
  logic [H:0]       mul_a_out;
  logic [H:0]       mul_b_out;
  logic             mul_ready_in;
  logic [PZ-1:0]    mul_product_in;

  int n_pass  = 0;
  int n_total = 0;

  karatsuba_sequencer #(.WIDTH(W)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .valid_in       (valid_in),
    .input_1        (input_1),
    .input_2        (input_2),
    .ready_out      (ready_out),
    .output_valid   (output_valid),
    .product        (product),
    .mul_start_out  (mul_start_out),
    .mul_a_out      (mul_a_out),
    .mul_b_out      (mul_b_out),
    .mul_ready_in   (mul_ready_in),
    .mul_product_in (mul_product_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Idle cycles with stray sub-multiplier responses, which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      mul_ready_in   = 1'($urandom_range(0, 1));
      mul_product_in = PZ'($urandom);
      @(posedge clk_in);
      @(negedge clk_in);
      check("idle_no_valid", 64'(output_valid), 64'(0));
      check("idle_no_start", 64'(mul_start_out), 64'(0));
      check("idle_ready", 64'(ready_out), 64'(1));
    end
    mul_ready_in = 1'b0;
  endtask

  // One request, entered and left at a falling edge. Cycle 1 is the cycle
  // right after the accepting edge. abort_at > 0 returns early in the first
  // WAIT cycle after that many start pulses.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int l0, input int l1, input int l2,
                        input bit poke, input int abort_at);
    logic [H:0]     ea [3];
    logic [H:0]     eb [3];
    int             lat [3];
    logic [H-1:0]   lo1, hi1, lo2, hi2;
    logic [2*W-1:0] exp_p;
    bit             fast, pending, done;
    int             nexp, exp_lat, c, starts, cnt, phase;
    lo1 = a[H-1:0]; hi1 = a[W-1:H];
    lo2 = b[H-1:0]; hi2 = b[W-1:H];
    ea[0] = {1'b0, lo1};               eb[0] = {1'b0, lo2};
    ea[1] = {1'b0, lo1} + {1'b0, hi1}; eb[1] = {1'b0, lo2} + {1'b0, hi2};
    ea[2] = {1'b0, hi1};               eb[2] = {1'b0, hi2};
    lat[0] = l0; lat[1] = l1; lat[2] = l2;
    fast    = (hi1 == '0) && (hi2 == '0);
    nexp    = fast ? 1 : 3;
    exp_lat = fast ? (l0 + 1) + 2 : (l0 + 1) + (l1 + 1) + (l2 + 1) + 2;
    exp_p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};

    check("ready_before_accept", 64'(ready_out), 64'(1));
    valid_in = 1'b1;
    input_1  = a;
    input_2  = b;
    @(posedge clk_in);
    @(negedge clk_in);
    c = 1; starts = 0; pending = 0; done = 0; cnt = 0; phase = 0;
    while (!done) begin
      mul_ready_in = 1'b0;
      if (output_valid) begin
        check("product", 64'(product), 64'(exp_p));
        check("latency", 64'(c), 64'(exp_lat));
        check("start_count", 64'(starts), 64'(nexp));
        check("ready_with_valid", 64'(ready_out), 64'(1));
        valid_in = 1'b0;
        done = 1;
      end else begin
        check("busy_ready_low", 64'(ready_out), 64'(0));
        if (mul_start_out) begin
          if (starts < nexp) begin
            phase = starts;
            check("start_op_a", 64'(mul_a_out), 64'(ea[phase]));
            check("start_op_b", 64'(mul_b_out), 64'(eb[phase]));
            cnt = lat[phase];
            pending = 1;
          end else begin
            check("extra_start", 64'(starts + 1), 64'(nexp));
          end
          starts++;
        end else if (pending) begin
          check("wait_op_a_stable", 64'(mul_a_out), 64'(ea[phase]));
          check("wait_op_b_stable", 64'(mul_b_out), 64'(eb[phase]));
          cnt--;
          if (cnt == 0) begin
            mul_ready_in   = 1'b1;
            mul_product_in = PZ'(ea[phase]) * PZ'(eb[phase]);
            pending = 0;
          end
        end
        if (abort_at > 0 && starts == abort_at && pending && !mul_start_out) begin
          valid_in     = 1'b0;
          mul_ready_in = 1'b0;
          return;
        end
        valid_in = poke;
        input_1  = W'($urandom);
        input_2  = W'($urandom);
        if (c >= 300) begin
          check("timeout", 64'(c), 64'(exp_lat));
          valid_in = 1'b0;
          done = 1;
        end
      end
      if (!done) begin
        @(posedge clk_in);
        @(negedge clk_in);
        c++;
      end
    end
  endtask

  initial begin
    rst_in         = 1'b0;
    valid_in       = 1'b0;
    input_1        = '0;
    input_2        = '0;
    mul_ready_in   = 1'b0;
    mul_product_in = '0;

    // Reset state
    repeat (2) @(negedge clk_in);
    check("rst_ready", 64'(ready_out), 64'(1));
    check("rst_valid", 64'(output_valid), 64'(0));
    check("rst_product", 64'(product), 64'(0));
    check("rst_start", 64'(mul_start_out), 64'(0));
    check("rst_mul_a", 64'(mul_a_out), 64'(0));
    check("rst_mul_b", 64'(mul_b_out), 64'(0));
    rst_in = 1'b1;
    idle(2);

    // Directed cases
    run_op(8'hAB, 8'hCD, 1, 1, 1, 0, 0);
    idle(2);
    run_op(8'hFF, 8'hFF, 1, 1, 1, 0, 0);
    idle(1);
    run_op(8'h0C, 8'h09, 1, 1, 1, 0, 0);
    idle(1);
    run_op(8'h00, 8'hA5, 1, 3, 5, 0, 0);
    idle(1);
    run_op(8'h80, 8'h02, 5, 3, 1, 0, 0);
    idle(1);

    // Back-to-back with valid_in held while busy
    run_op(8'hAB, 8'hCD, 1, 1, 1, 1, 0);
    run_op(8'h12, 8'h34, 1, 1, 1, 1, 0);
    idle(2);

    // Randomized operands, latencies, pokes and spacing
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 4 == 0) begin
        ra[W-1:H] = '0;
        rb[W-1:H] = '0;
      end
      run_op(ra, rb, $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
             1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

    // Reset in Z1_WAIT, then a stray late response
    run_op(8'hAB, 8'hCD, 5, 5, 5, 0, 2);
    rst_in = 1'b0;
    #1;
    check("abort_valid", 64'(output_valid), 64'(0));
    check("abort_product", 64'(product), 64'(0));
    check("abort_start", 64'(mul_start_out), 64'(0));
    check("abort_mul_a", 64'(mul_a_out), 64'(0));
    check("abort_mul_b", 64'(mul_b_out), 64'(0));
    check("abort_ready", 64'(ready_out), 64'(1));
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    mul_ready_in   = 1'b1;
    mul_product_in = '1;
    @(posedge clk_in);
    @(negedge clk_in);
    mul_ready_in = 1'b0;
    check("stray_valid", 64'(output_valid), 64'(0));
    check("stray_ready", 64'(ready_out), 64'(1));
    check("stray_start", 64'(mul_start_out), 64'(0));
    check("stray_product", 64'(product), 64'(0));
    idle(3);
    run_op(8'hAB, 8'hCD, 1, 1, 1, 0, 0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
